// File: rtl/dec_pkg.sv
// Shared types and constants for the index decode / sweep display blocks.
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  // Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_TABLE [8] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000  // 7
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_lut.sv
// Combinational 3-bit index to active-low 7-segment pattern lookup.
module seg7_lut
  import dec_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic [6:0] o_seg
);

  // Pure table lookup; the consumer registers the result.
  always_comb begin
    o_seg = SEG_TABLE[i_idx];
  end

endmodule

// File: rtl/dec_sweep.sv
// One-hot / 7-segment index display: single timed show or timed sweep 0..target.
module dec_sweep
  import dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic       mode,
  input  logic [2:0] code,
  output logic [7:0] onehot,
  output logic [2:0] idx,
  output logic [6:0] seg,
  output logic       busy
);

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] STEP_LD = 8'(STEP_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_tgt;
  logic [2:0] r_idx;
  logic [7:0] r_onehot;
  logic [6:0] r_seg;
  logic       r_busy;

  state_t     w_state_n;
  logic [7:0] w_cnt_n;
  logic [2:0] w_tgt_n;
  logic [2:0] w_idx_n;
  logic [6:0] w_seg_n;

  // The lookup is fed the next index so seg lands in the same cycle as idx.
  seg7_lut u_seg7_lut (
    .i_idx (w_idx_n),
    .o_seg (w_seg_n)
  );

  // Next-state, counter, target and index computation.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_tgt_n   = r_tgt;
    w_idx_n   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          if (mode) begin
            w_state_n = ST_SWEEP;
            w_tgt_n   = code;
            w_idx_n   = '0;
            w_cnt_n   = STEP_LD;
          end else begin
            w_state_n = ST_SHOW;
            w_idx_n   = code;
            w_cnt_n   = HOLD_LD;
          end
        end
      end
      ST_SHOW: begin
        if (r_cnt == '0) begin
          w_state_n = ST_IDLE;
          w_idx_n   = '0;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      ST_SWEEP: begin
        if (r_cnt == '0) begin
          if (r_idx == r_tgt) begin
            w_state_n = ST_IDLE;
            w_idx_n   = '0;
          end else begin
            w_idx_n = r_idx + 3'd1;
            w_cnt_n = STEP_LD;
          end
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_idx_n   = '0;
        w_cnt_n   = '0;
      end
    endcase
    if (!en) begin
      w_state_n = ST_IDLE;
      w_idx_n   = '0;
      w_cnt_n   = '0;
    end
  end

  // State and registered outputs; reset overrides enable and load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tgt    <= '0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_seg    <= SEG_BLANK;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_tgt   <= w_tgt_n;
      r_idx   <= w_idx_n;
      r_busy  <= (w_state_n != ST_IDLE);
      if (w_state_n != ST_IDLE) begin
        r_onehot <= 8'd1 << w_idx_n;
        r_seg    <= w_seg_n;
      end else begin
        r_onehot <= '0;
        r_seg    <= SEG_BLANK;
      end
    end
  end

  assign onehot = r_onehot;
  assign idx    = r_idx;
  assign seg    = r_seg;
  assign busy   = r_busy;

endmodule

// File: tb/tb_dec_sweep.sv
// Randomised and directed bench for dec_sweep against a timeline reference model.
module tb_dec_sweep;

  localparam int unsigned HOLD = 8;
  localparam int unsigned STEP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic       mode;
  logic [2:0] code;
  logic [7:0] onehot;
  logic [2:0] idx;
  logic [6:0] seg;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: an operation is a start time plus a known total length.
  bit          m_active = 1'b0;
  bit          m_mode   = 1'b0;
  int unsigned m_tgt    = 0;
  int unsigned m_el     = 0;
  int unsigned m_total  = 0;

  logic [6:0] ref_seg [8];

  dec_sweep #(.HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .mode   (mode),
    .code   (code),
    .onehot (onehot),
    .idx    (idx),
    .seg    (seg),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n || !en) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_el++;
      if (m_el == m_total) m_active = 1'b0;
    end else if (load) begin
      m_active = 1'b1;
      m_mode   = mode;
      m_tgt    = code;
      m_el     = 0;
      m_total  = mode ? (int'(code) + 1) * STEP : HOLD;
    end
  endtask

  task automatic check_outputs();
    int unsigned e_idx;
    logic [7:0]  e_oh;
    logic [6:0]  e_seg;
    e_idx = 0;
    e_oh  = '0;
    e_seg = 7'b1111111;
    if (m_active) begin
      e_idx = m_mode ? (m_el / STEP) : m_tgt;
      e_oh  = 8'd1 << e_idx;
      e_seg = ref_seg[e_idx];
    end
    chk("busy",   32'(busy),   32'(m_active));
    chk("idx",    32'(idx),    32'(e_idx));
    chk("onehot", 32'(onehot), 32'(e_oh));
    chk("seg",    32'(seg),    32'(e_seg));
  endtask

  task automatic tick(input logic r, input logic e, input logic l, input logic m, input logic [2:0] c);
    rst_n = r;
    en    = e;
    load  = l;
    mode  = m;
    code  = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    ref_seg[0] = 7'b1000000; ref_seg[1] = 7'b1111001;
    ref_seg[2] = 7'b0100100; ref_seg[3] = 7'b0110000;
    ref_seg[4] = 7'b0011001; ref_seg[5] = 7'b0010010;
    ref_seg[6] = 7'b0000010; ref_seg[7] = 7'b1111000;

    tick(1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Single show of 5, first load right after reset release.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 3'd5);
    idle_cycles(HOLD + 2);

    // Sweep to 3, then the degenerate sweep to 0.
    tick(1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
    idle_cycles(4 * STEP + 2);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    idle_cycles(STEP + 2);

    // Load with enable low has no effect.
    tick(1'b1, 1'b0, 1'b1, 1'b0, 3'd4);
    idle_cycles(2);

    // Second load during a show is ignored; reload on the completion edge too.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 3'd7);
    for (int unsigned i = 0; i < HOLD - 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 3'd6);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    idle_cycles(HOLD + 1);

    // Enable dropped in the third cycle of a sweep.
    tick(1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
    idle_cycles(2);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    idle_cycles(2);

    // Reset mid-show.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 3'd6);
    idle_cycles(3);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    idle_cycles(2);

    // Every code in single-show mode.
    for (int unsigned c = 0; c < 8; c++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 3'(c));
      idle_cycles(HOLD + 1);
    end

    // Random traffic.
    for (int unsigned i = 0; i < 1500; i++) begin
      tick(logic'($urandom_range(0, 99) != 0),
           logic'($urandom_range(0, 19) != 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dec_sweep.md
DEC_SWEEP -- requirements
Module: dec_sweep

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: number of cycles a single decoded output is shown; legal range 1..255.
REQ-002 SHALL have parameter STEP_CYCLES, default 4: number of cycles each index is shown during a sweep; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; every register updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-005 SHALL have port en, input, 1: block enable; low forces the idle state.
REQ-006 SHALL have port load, input, 1: start strobe, sampled on the rising clk edge.
REQ-007 SHALL have port mode, input, 1: 0 = single show, 1 = sweep; sampled with load.
REQ-008 SHALL have port code, input, 3: index to decode; sampled with load.
REQ-009 SHALL have port onehot, output, 8: registered active-high one-hot of the current index; all-zero when idle.
REQ-010 SHALL have port idx, output, 3: registered current index; 0 when idle.
REQ-011 SHALL have port seg, output, 7: registered active-low 7-segment pattern of idx, ordered {g,f,e,d,c,b,a}.
REQ-012 SHALL have port busy, output, 1: registered; high in SHOW and SWEEP.

Function
REQ-013 SHALL implement FSM states IDLE, SHOW and SWEEP, plus an 8-bit cycle counter cnt and a 3-bit latched target tgt.
REQ-014 SHALL, in IDLE, drive onehot = 8'h00, idx = 0, seg = 7'b1111111 and busy = 0.
REQ-015 SHALL, when IDLE and en=1, load=1, mode=0 at edge k, enter SHOW at edge k, with idx = code, onehot = 1<<code, busy = 1 visible from cycle k+1.
REQ-016 SHALL hold SHOW for exactly HOLD_CYCLES cycles, then return to IDLE.
REQ-017 SHALL, when IDLE and en=1, load=1, mode=1 at edge k, enter SWEEP with tgt = code and idx = 0, visible from cycle k+1.
REQ-018 SHALL, in SWEEP, keep each idx for STEP_CYCLES cycles and then increment it; after idx = tgt has been shown for STEP_CYCLES cycles, return to IDLE.
REQ-019 SHALL give SWEEP a total busy time of (tgt+1)*STEP_CYCLES cycles; tgt = 0 degenerates to a single step showing index 0.
REQ-020 SHALL use this seg table (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-021 SHALL ignore load while busy = 1; no restart and no change of tgt or mode.
REQ-022 SHALL go to IDLE at the next edge when en = 0 in any state, with idle outputs per REQ-014; en = 0 wins over a simultaneous load.
REQ-023 SHALL accept load = 1 on the same edge that SHOW or SWEEP completes only on the following edge, since the FSM is IDLE for at least one cycle between operations.
REQ-024 SHALL guarantee that onehot always has at most one bit set, and that onehot, idx and seg are mutually consistent in every cycle.
REQ-025 SHALL load cnt with the hold or step value minus 1, decrement it, and act at zero; cnt SHALL never wrap.

Reset
REQ-026 SHALL, when rst_n = 0 at a rising edge, force IDLE, cnt = 0, tgt = 0 and all outputs to the REQ-014 values, overriding en and load.
REQ-027 SHALL, on reset asserted mid-SHOW or mid-SWEEP, abort the operation with no residual output after the reset edge.
REQ-028 SHALL require no reset-release sequencing; the first load is accepted on the first edge with rst_n = 1.

Structure
REQ-029 SHALL place the state enum (IDLE/SHOW/SWEEP) and the 8-entry seg table constant in shared package dec_pkg, reused by display blocks.
REQ-030 SHALL use a single combinational sub-module seg7_lut (3-bit index in, 7-bit active-low pattern out), whose output is registered in dec_sweep.
REQ-031 SHALL keep the FSM, counter and output registers in dec_sweep; the target size is 120-400 lines of RTL.

Verification
REQ-032 SHALL cover: HOLD=8, load, mode=0, code=5 -> onehot = 8'h20, seg = 0010010, busy = 1 for exactly 8 cycles, then all-idle values.
REQ-033 SHALL cover: STEP=4, load, mode=1, code=3 -> idx = 0,1,2,3 for 4 cycles each (onehot 01,02,04,08), busy = 1 for 16 cycles.
REQ-034 SHALL cover: load, mode=1, code=0 -> one step of idx = 0, seg = 1000000, then IDLE; and load with en = 0 -> no response.
REQ-035 SHALL cover: a second load with code=7 during a SHOW of code=2 -> ignored, onehot stays 8'h04 until the hold expires.
REQ-036 SHALL cover: en dropped in the third cycle of a sweep -> idle values on the next edge; and rst_n = 0 mid-SHOW -> idle on the reset edge.
REQ-037 SHALL cover: all 8 codes in mode 0 -> seg matches the REQ-020 table, with exactly one onehot bit set every cycle.
